// File: rtl/gost_block_loader_pkg.sv
// Shared widths, byte counts and FSM encodings for the GOST 28147-89 stream loader.
package gost_defs;

    localparam int GOST_KEY_W = 256;
    localparam int GOST_BLK_W = 64;
    localparam int KEY_BYTES  = 32;
    localparam int BLK_BYTES  = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_KEY  = 3'd1;
    localparam logic [2:0] ST_MSG  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    // States in which the stream may deliver bytes.
    function automatic logic accepts_bytes(input logic [2:0] st);
        logic ok;
        case (st)
            ST_IDLE, ST_KEY, ST_MSG: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/gost_byte_shifter.sv
// MSB-first byte shift register used as the key and message shadow.
// clr together with shift restarts the shadow with the incoming byte.
module gost_byte_shifter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         shift_i,
    input  logic [7:0]   byte_i,
    output logic [W-1:0] shift_val_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Value the shadow takes once byte_i is appended.
    assign shift_val_o = {data_q[W-9:0], byte_i};

    // Next shadow content.
    always_comb begin
        data_d = data_q;
        if (shift_i) begin
            if (clr_i) begin
                data_d = {{(W-8){1'b0}}, byte_i};
            end else begin
                data_d = {data_q[W-9:0], byte_i};
            end
        end else if (clr_i) begin
            data_d = {W{1'b0}};
        end else begin
            data_d = data_q;
        end
    end

    // Shadow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {W{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/gost_block_loader.sv
// Byte-stream front end feeding key/message to a GOST 28147-89 core.
// Optional GOST_LOADER_KEY_LOCK_EN freezes the key after the first full load.
module gost_block_loader
    import gost_defs::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_is_key,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [GOST_KEY_W-1:0] key,
    output logic                  key_valid,
    output logic [GOST_BLK_W-1:0] message,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int HCW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    logic [2:0]            state_q, state_d;
    logic [4:0]            byte_cnt_q, byte_cnt_d;
    logic [HCW-1:0]        hold_q, hold_d;
    logic [GOST_KEY_W-1:0] key_q, key_d;
    logic [GOST_BLK_W-1:0] msg_q, msg_d;
    logic                  key_valid_q, key_valid_d;
    logic                  out_valid_q, out_valid_d;
    logic                  err_q, err_d;
    logic                  in_ready_q, in_ready_d;

    logic                  key_clr_s, key_shift_s, msg_clr_s, msg_shift_s;
    logic [GOST_KEY_W-1:0] key_next_s;
    logic [GOST_BLK_W-1:0] msg_next_s;
    logic                  accept_s;
    logic                  key_locked_s;

`ifdef GOST_LOADER_KEY_LOCK_EN
    assign key_locked_s = key_valid_q;
`else
    assign key_locked_s = 1'b0;
`endif

    assign accept_s = in_valid & in_ready_q;

    gost_byte_shifter #(.W(GOST_KEY_W)) u_key_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (key_clr_s),
        .shift_i     (key_shift_s),
        .byte_i      (in_data),
        .shift_val_o (key_next_s)
    );

    gost_byte_shifter #(.W(GOST_BLK_W)) u_msg_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (msg_clr_s),
        .shift_i     (msg_shift_s),
        .byte_i      (in_data),
        .shift_val_o (msg_next_s)
    );

    // Collection FSM: shadows fill byte by byte, visible outputs change only on completion.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        hold_d      = hold_q;
        key_d       = key_q;
        msg_d       = msg_q;
        key_valid_d = key_valid_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        key_clr_s   = 1'b0;
        key_shift_s = 1'b0;
        msg_clr_s   = 1'b0;
        msg_shift_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && in_is_key) begin
                    if (key_locked_s) begin
                        err_d = 1'b1;
                    end else begin
                        key_clr_s   = 1'b1;
                        key_shift_s = 1'b1;
                        byte_cnt_d  = 5'd1;
                        state_d     = ST_KEY;
                    end
                end else if (accept_s) begin
                    msg_clr_s   = 1'b1;
                    msg_shift_s = 1'b1;
                    byte_cnt_d  = 5'd1;
                    state_d     = ST_MSG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY: begin
                if (accept_s && in_is_key) begin
                    key_shift_s = 1'b1;
                    if (byte_cnt_q == 5'(KEY_BYTES - 1)) begin
                        key_d       = key_next_s;
                        key_valid_d = 1'b1;
                        byte_cnt_d  = 5'd0;
                        state_d     = ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end else if (accept_s) begin
                    // Type switch: drop partial key, byte opens a message.
                    err_d       = 1'b1;
                    key_clr_s   = 1'b1;
                    msg_clr_s   = 1'b1;
                    msg_shift_s = 1'b1;
                    byte_cnt_d  = 5'd1;
                    state_d     = ST_MSG;
                end else begin
                    state_d = ST_KEY;
                end
            end
            ST_MSG: begin
                if (accept_s && !in_is_key) begin
                    msg_shift_s = 1'b1;
                    if (byte_cnt_q == 5'(BLK_BYTES - 1)) begin
                        byte_cnt_d = 5'd0;
                        if (key_valid_q) begin
                            msg_d   = msg_next_s;
                            hold_d  = {HCW{1'b0}};
                            state_d = ST_WAIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end else if (accept_s) begin
                    err_d     = 1'b1;
                    msg_clr_s = 1'b1;
                    if (key_locked_s) begin
                        byte_cnt_d = 5'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        key_clr_s   = 1'b1;
                        key_shift_s = 1'b1;
                        byte_cnt_d  = 5'd1;
                        state_d     = ST_KEY;
                    end
                end else begin
                    state_d = ST_MSG;
                end
            end
            ST_WAIT: begin
                // Give the core a settled message before announcing it.
                if (hold_q == HCW'(HOLD_CYCLES)) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                byte_cnt_d  = 5'd0;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = accepts_bytes(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= 5'd0;
            hold_q      <= {HCW{1'b0}};
            key_q       <= {GOST_KEY_W{1'b0}};
            msg_q       <= {GOST_BLK_W{1'b0}};
            key_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            hold_q      <= hold_d;
            key_q       <= key_d;
            msg_q       <= msg_d;
            key_valid_q <= key_valid_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign message   = msg_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule
